// File: rtl/multi_dataflow_out_collector_pkg.sv
// Shared types and constants for the multi-dataflow output collector.
package multi_dataflow_package;

    localparam int unsigned COLLECTOR_FIFO_DEPTH = 4;
    localparam int unsigned COLLECTOR_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        COLL_IDLE  = 2'd0,
        COLL_RUN   = 2'd1,
        COLL_DRAIN = 2'd2,
        COLL_DONE  = 2'd3
    } collector_state_e;

    typedef struct packed {
        logic                           start;
        logic                           clear;
        logic [COLLECTOR_CNT_WIDTH-1:0] len;
    } ctrl_collector_t;

    typedef struct packed {
        logic                           busy;
        logic                           done;
        logic [COLLECTOR_CNT_WIDTH-1:0] cnt;
    } flags_collector_t;

    // Pointer width carries one extra wrap bit to tell full from empty.
    function automatic int unsigned collector_ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle with byte strobes, as used between HWPE streamers.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/multi_dataflow_collector_fifo.sv
// Synchronous non-bypass FIFO with registered full/empty flags and wrap-bit pointers.
module multi_dataflow_collector_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
    logic                  full_reg, full_next;
    logic                  empty_reg, empty_next;
    logic                  push_ok, pop_ok;
    logic [DEPTH-1:0]      wr_en;
    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

    assign push_ok = push_i && !full_reg;
    assign pop_ok  = pop_i && !empty_reg;

    assign wr_ptr_next = wr_ptr_reg + PW'(push_ok);
    assign rd_ptr_next = rd_ptr_reg + PW'(pop_ok);

    assign empty_next = (wr_ptr_next == rd_ptr_next);
    assign full_next  = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                        (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push_ok && (wr_ptr_reg[AW-1:0] == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            full_reg   <= full_next;
            empty_reg  <= empty_next;
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    mem_reg[i] <= data_i;
                end
            end
        end
    end

    // Head is read straight from storage so a beat written in cycle N shows in N+1.
    assign data_o  = mem_reg[rd_ptr_reg[AW-1:0]];
    assign full_o  = full_reg;
    assign empty_o = empty_reg;

endmodule

// File: rtl/multi_dataflow_out_collector.sv
// Collects a programmed number of engine output beats and forwards them to the source streamer.
module multi_dataflow_out_collector
    import multi_dataflow_package::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = COLLECTOR_FIFO_DEPTH,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] len_i,
    hwpe_stream_intf_stream.sink   stream_i,
    hwpe_stream_intf_stream.source stream_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_WIDTH-1:0] cnt_o
);
    collector_state_e      state_reg, state_next;
    logic [CNT_WIDTH-1:0]  len_reg, len_next;
    logic [CNT_WIDTH-1:0]  cnt_in_reg, cnt_in_next;
    logic [CNT_WIDTH-1:0]  cnt_out_reg, cnt_out_next;

    logic                  fifo_push, fifo_pop;
    logic                  fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  unused_strb;

    // Upstream strobes are not forwarded; every outgoing beat is full-width.
    assign unused_strb = ^stream_i.strb;

    // Ready is a function of registered state only, never of downstream ready.
    assign stream_i.ready = (state_reg == COLL_RUN) && !fifo_full;
    assign fifo_push      = stream_i.valid && stream_i.ready;
    assign fifo_pop       = !fifo_empty && stream_o.ready;

    multi_dataflow_collector_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (fifo_push),
        .data_i  (stream_i.data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_next   = state_reg;
        len_next     = len_reg;
        cnt_in_next  = cnt_in_reg;
        cnt_out_next = cnt_out_reg + CNT_WIDTH'(fifo_pop);

        unique case (state_reg)
            COLL_IDLE: begin
                if (start_i) begin
                    len_next     = len_i;
                    cnt_in_next  = '0;
                    cnt_out_next = '0;
                    state_next   = (len_i == '0) ? COLL_DONE : COLL_RUN;
                end
            end
            COLL_RUN: begin
                if (fifo_push) begin
                    cnt_in_next = cnt_in_reg + CNT_WIDTH'(1);
                    if ((cnt_in_reg + CNT_WIDTH'(1)) == len_reg) begin
                        state_next = COLL_DRAIN;
                    end
                end
            end
            COLL_DRAIN: begin
                // Look at the post-pop count so DONE follows the last pop by one cycle.
                if (cnt_out_next == len_reg) begin
                    state_next = COLL_DONE;
                end
            end
            COLL_DONE: begin
                state_next = COLL_IDLE;
            end
            default: begin
                state_next = COLL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_reg   <= COLL_IDLE;
            len_reg     <= '0;
            cnt_in_reg  <= '0;
            cnt_out_reg <= '0;
        end else begin
            state_reg   <= state_next;
            len_reg     <= len_next;
            cnt_in_reg  <= cnt_in_next;
            cnt_out_reg <= cnt_out_next;
        end
    end

    assign stream_o.valid = !fifo_empty;
    assign stream_o.data  = fifo_data;
    assign stream_o.strb  = '1;

    assign busy_o = (state_reg == COLL_RUN) || (state_reg == COLL_DRAIN);
    assign done_o = (state_reg == COLL_DONE);
    assign cnt_o  = cnt_out_reg;

endmodule

// File: tb/tb_multi_dataflow_out_collector.sv
// Scoreboard bench for the output collector: directed jobs, queued expectations, negedge monitor.
module tb_multi_dataflow_out_collector;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          start_i;
    logic [CW-1:0] len_i;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] cnt_o;

    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) in_s ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) out_s ();

    multi_dataflow_out_collector #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (4),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .clear_i  (clear_i),
        .start_i  (start_i),
        .len_i    (len_i),
        .stream_i (in_s),
        .stream_o (out_s),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .cnt_o    (cnt_o)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [DW-1:0] src_q [$];
    logic [DW-1:0] exp_q [$];
    bit            src_en = 1'b0;
    bit            ds_alt = 1'b0;
    int            in_hs_cnt = 0;
    int            pop_cnt = 0;
    int            last_pop_cyc = 0;
    int            done_cyc = 0;
    logic          up_hs;
    logic          prev_stall;
    logic [DW-1:0] prev_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Upstream source: presents the head of src_q, retires it after a handshake.
    initial begin
        in_s.valid = 1'b0;
        in_s.data  = '0;
        in_s.strb  = '1;
        forever begin
            @(negedge clk);
            up_hs = in_s.valid && in_s.ready;
            @(posedge clk);
            #1;
            if (up_hs && src_q.size() > 0) begin
                void'(src_q.pop_front());
                in_hs_cnt++;
            end
            in_s.valid = src_en && (src_q.size() > 0);
            in_s.data  = (src_q.size() > 0) ? src_q[0] : '0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (ds_alt) out_s.ready = ~out_s.ready;
    end

    // Monitor: pops the scoreboard on every output handshake and checks stall stability.
    initial begin
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                check("hold_valid", 64'(out_s.valid), 64'd1);
                check("hold_data", 64'(out_s.data), 64'(prev_data));
            end
            if (out_s.valid && out_s.ready) begin
                pop_cnt++;
                last_pop_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", out_s.data);
                end else begin
                    check("beat_data", 64'(out_s.data), 64'(exp_q.pop_front()));
                    check("beat_strb", 64'(out_s.strb), 64'hf);
                end
            end
            prev_stall = rst_ni && !clear_i && out_s.valid && !out_s.ready;
            prev_data  = out_s.data;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_job(input int len);
        tick();
        start_i = 1'b1;
        len_i   = CW'(len);
        tick();
        start_i = 1'b0;
    endtask

    task automatic prep_job(input int nbeats, input int nexp, input logic [DW-1:0] base);
        for (int i = 0; i < nbeats; i++) src_q.push_back(base + DW'(i));
        for (int i = 0; i < nexp; i++) exp_q.push_back(base + DW'(i));
        src_en    = 1'b1;
        in_hs_cnt = 0;
        pop_cnt   = 0;
    endtask

    task automatic wait_done(input int budget, output int k);
        k = 0;
        while (1) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            k++;
            if (k > budget) begin
                checks++;
                errors++;
                $display("FAIL done_timeout actual=none required=done_within_%0d", budget);
                break;
            end
        end
    endtask

    task automatic job_end(input int len, input int exp_k, input int k);
        if (exp_k >= 0) check("done_latency", 64'(k), 64'(exp_k));
        check("cnt_at_done", 64'(cnt_o), 64'(len));
        check("pop_count", 64'(pop_cnt), 64'(len));
        check("busy_at_done", 64'(busy_o), 64'd0);
        if (len > 0) check("done_after_last_pop", 64'(done_cyc), 64'(last_pop_cyc + 1));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check("done_one_cycle", 64'(done_o), 64'd0);
        check("idle_in_ready", 64'(in_s.ready), 64'd0);
        check("cnt_hold", 64'(cnt_o), 64'(len));
    endtask

    initial begin
        int k;
        rst_ni      = 1'b0;
        clear_i     = 1'b0;
        start_i     = 1'b0;
        len_i       = '0;
        out_s.ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_s.ready), 64'd0);
        check("rst_out_valid", 64'(out_s.valid), 64'd0);
        check("rst_out_data", 64'(out_s.data), 64'd0);
        check("rst_out_strb", 64'(out_s.strb), 64'hf);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_cnt", 64'(cnt_o), 64'd0);
        tick();
        rst_ni = 1'b1;

        // Single job, len 8, free-flowing
        prep_job(8, 8, 32'hA000_0000);
        start_job(8);
        @(negedge clk);
        check("run_busy", 64'(busy_o), 64'd1);
        wait_done(40, k);
        job_end(8, 8, k);

        // Backpressure, len 6, downstream stalled at first
        tick();
        out_s.ready = 1'b0;
        prep_job(6, 6, 32'hB000_0000);
        start_job(6);
        repeat (6) @(negedge clk);
        check("bp_pushes", 64'(in_hs_cnt), 64'd4);
        check("bp_in_ready", 64'(in_s.ready), 64'd0);
        check("bp_out_valid", 64'(out_s.valid), 64'd1);
        check("bp_out_head", 64'(out_s.data), 64'h0000_0000_B000_0000);
        repeat (4) tick();
        out_s.ready = 1'b1;
        wait_done(40, k);
        job_end(6, -1, k);

        // Zero length with a stray upstream beat
        tick();
        prep_job(1, 0, 32'hC000_0000);
        start_job(0);
        wait_done(10, k);
        job_end(0, 0, k);
        check("zero_no_push", 64'(in_hs_cnt), 64'd0);
        tick();
        src_q.delete();

        // Extra beats: 5 offered, 3 accepted
        tick();
        prep_job(5, 3, 32'hD000_0000);
        start_job(3);
        wait_done(20, k);
        job_end(3, 4, k);
        check("extra_accepted", 64'(in_hs_cnt), 64'd3);
        check("extra_pending", 64'(src_q.size()), 64'd2);
        check("extra_up_valid", 64'(in_s.valid), 64'd1);
        check("extra_up_ready", 64'(in_s.ready), 64'd0);
        tick();
        src_q.delete();

        // Clear mid-job with two beats buffered
        tick();
        out_s.ready = 1'b0;
        prep_job(5, 0, 32'hE000_0000);
        start_job(5);
        tick();
        tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        src_q.delete();
        @(negedge clk);
        check("clr_out_valid", 64'(out_s.valid), 64'd0);
        check("clr_cnt", 64'(cnt_o), 64'd0);
        check("clr_busy", 64'(busy_o), 64'd0);
        check("clr_in_ready", 64'(in_s.ready), 64'd0);
        tick();
        out_s.ready = 1'b1;
        prep_job(2, 2, 32'hF000_0000);
        start_job(2);
        wait_done(20, k);
        job_end(2, 3, k);

        // Reset mid-job
        tick();
        out_s.ready = 1'b0;
        prep_job(5, 0, 32'h1100_0000);
        start_job(5);
        tick();
        tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        src_q.delete();
        @(negedge clk);
        check("rst_mid_out_valid", 64'(out_s.valid), 64'd0);
        check("rst_mid_cnt", 64'(cnt_o), 64'd0);
        check("rst_mid_busy", 64'(busy_o), 64'd0);
        tick();
        out_s.ready = 1'b1;
        prep_job(2, 2, 32'h2200_0000);
        start_job(2);
        wait_done(20, k);
        job_end(2, 3, k);

        // Ignored start during RUN, pointer wrap with alternating downstream ready
        tick();
        out_s.ready = 1'b1;
        ds_alt      = 1'b1;
        prep_job(10, 10, 32'h3300_0000);
        start_job(10);
        tick();
        start_i = 1'b1;
        len_i   = CW'(1);
        tick();
        start_i = 1'b0;
        @(negedge clk);
        check("ign_start_busy", 64'(busy_o), 64'd1);
        wait_done(100, k);
        job_end(10, -1, k);
        ds_alt = 1'b0;
        tick();
        out_s.ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
